cpu_debug_trace: RTL

- Consumer end of the CPU debug interface (debug_opcode, debug_pc_write, debug_branch).
- Records one trace entry per retired instruction (debug_pc_write high) into an on-chip FIFO, with an optional opcode trigger.
- A host or bench drains entries over a valid/ready read port.
- Sits beside cpu in the top level and testbench and shares its clock.

---
 rtl/cpu_debug_pkg.sv | 28 ++
 rtl/trace_fifo.sv | 65 ++++++
 rtl/cpu_debug_trace.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_debug_pkg.sv
// Shared encodings and rd_data field layout for the CPU debug trace recorder.
package cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_STOPPED = 2'd3
    } state_e;

    localparam int unsigned DEF_OPC_W   = 4;
    localparam int unsigned DEF_DELTA_W = 8;

    // rd_data = {opcode, branch, delta}, opcode in the MSBs
    localparam int unsigned DELTA_MSB = DEF_DELTA_W - 1;
    localparam int unsigned BR_BIT    = DEF_DELTA_W;
    localparam int unsigned OPC_LSB   = DEF_DELTA_W + 1;
    localparam int unsigned ENTRY_W   = DEF_OPC_W + 1 + DEF_DELTA_W;

    localparam int unsigned DROP_MAX  = 255;

    typedef struct packed {
        logic [DEF_OPC_W-1:0]   opcode;
        logic                   branch;
        logic [DEF_DELTA_W-1:0] delta;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with flush; occupancy tracked separately from the pointers.
module trace_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Flush outranks any push or pop in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_rdata = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/cpu_debug_trace.sv
// Trace recorder on the CPU debug port: arm/trigger FSM, cycle-delta stamping,
// drop accounting, and a show-ahead read port backed by trace_fifo.
module cpu_debug_trace
    import cpu_debug_pkg::*;
#(
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DELTA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [OPC_W-1:0]           debug_opcode,
    input  logic                       debug_pc_write,
    input  logic                       debug_branch,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [OPC_W-1:0]           trig_opcode,
    input  logic                       stop_on_full,
    output logic                       rd_valid,
    output logic [OPC_W+DELTA_W:0]     rd_data,
    input  logic                       rd_ready,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 dropped
);

    localparam int unsigned ENTRY_W = OPC_W + 1 + DELTA_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [DELTA_W-1:0] DELTA_SAT = '1;

    state_e               r_state;
    state_e               w_next;
    logic                 r_trig_en;
    logic [OPC_W-1:0]     r_trig_opcode;
    logic [DELTA_W-1:0]   r_delta;
    logic                 r_have_prev;
    logic                 r_overflow;
    logic [7:0]           r_dropped;

    logic                 w_event;
    logic                 w_match;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push_req;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_stop;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_wdata;
    logic [CNT_W-1:0]     w_count;

    assign w_event = debug_pc_write && !arm;
    assign w_match = r_trig_en && (debug_opcode == r_trig_opcode);
    assign w_pop   = rd_ready && rd_valid && !arm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (arm) begin
            w_next = trig_en ? ST_ARMED : ST_CAPTURE;
        end else if (w_stop) begin
            w_next = ST_STOPPED;
        end else if ((r_state == ST_ARMED) && w_push_req) begin
            w_next = ST_CAPTURE;
        end
    end

    // A push lands if there is room or a pop frees a slot in the same cycle
    always_comb begin
        w_push_req = 1'b0;
        case (r_state)
            ST_ARMED:   w_push_req = w_event && w_match;
            ST_CAPTURE: w_push_req = w_event;
            default:    w_push_req = 1'b0;
        endcase
        w_accept = w_push_req && (!w_full || w_pop);
        w_reject = w_push_req && !w_accept;
        w_stop   = stop_on_full &&
                   (w_reject || (w_accept && !w_pop && (w_count == CNT_W'(DEPTH - 1))));
        w_drop   = w_reject && !stop_on_full;
        w_wdata  = {debug_opcode, debug_branch, (r_have_prev ? r_delta : '0)};
    end

    // Delta restarts at 1 after each stored entry and only runs once a session has one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trig_en     <= 1'b0;
            r_trig_opcode <= '0;
            r_delta       <= '0;
            r_have_prev   <= 1'b0;
            r_overflow    <= 1'b0;
            r_dropped     <= '0;
        end else if (arm) begin
            r_trig_en     <= trig_en;
            r_trig_opcode <= trig_opcode;
            r_delta       <= '0;
            r_have_prev   <= 1'b0;
            r_overflow    <= 1'b0;
            r_dropped     <= '0;
        end else begin
            if (w_accept) begin
                r_delta     <= DELTA_W'(1);
                r_have_prev <= 1'b1;
            end else if (r_have_prev && (r_delta != DELTA_SAT)) begin
                r_delta <= r_delta + DELTA_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != 8'(DROP_MAX)) begin
                    r_dropped <= r_dropped + 8'd1;
                end
            end
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_flush (arm),
        .i_wdata (w_wdata),
        .o_rdata (rd_data),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign rd_valid = (w_count != '0);
    assign count    = w_count;
    assign state    = r_state;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;

endmodule
